// File: rtl/alu_writeback_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_wb_pkg
// Shared types and constants for the ALU writeback sequencer.
// Rev    : 1.0
// ============================================================================
package alu_wb_pkg;

  localparam int WB_N = 32;
  localparam int WB_R = 32;
  localparam int WB_O = $clog2(WB_R);

  localparam logic [WB_O-1:0] GPR_ZERO = '0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [WB_O-1:0] adr;
    logic [WB_N-1:0] dat;
  } gpr_wr_t;

endpackage
`default_nettype wire

// File: rtl/alu_writeback_sequencer_pick.sv
`default_nettype none
// ============================================================================
// Module : alu_wb_pick
// Lowest-set-bit select over the 3-slot pending mask (slot a has priority).
// Rev    : 1.0
// ============================================================================
module alu_wb_pick (
  input  logic [2:0] mask,
  output logic [1:0] idx,
  output logic [2:0] clr
);

  always_comb begin
    idx = 2'd0;
    clr = 3'b000;
    if (mask[0]) begin
      idx = 2'd0;
      clr = 3'b001;
    end else if (mask[1]) begin
      idx = 2'd1;
      clr = 3'b010;
    end else if (mask[2]) begin
      idx = 2'd2;
      clr = 3'b100;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_writeback_sequencer
// Serializes up to three GPR writes per ALU result bundle; owns HI/LO and O/Z.
// Rev    : 1.0
// ============================================================================
module alu_writeback_sequencer
  import alu_wb_pkg::*;
#(
  parameter  int N = WB_N,
  parameter  int R = WB_R,
  localparam int O = $clog2(R)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [O-1:0] GPR_a_adr,
  input  logic [N-1:0] GPR_a_dat,
  input  logic         GPR_a_val,
  input  logic [O-1:0] GPR_b_adr,
  input  logic [N-1:0] GPR_b_dat,
  input  logic         GPR_b_val,
  input  logic [O-1:0] GPR_c_adr,
  input  logic [N-1:0] GPR_c_dat,
  input  logic         GPR_c_val,
  input  logic [N-1:0] SPR_h_dat,
  input  logic         SPR_h_val,
  input  logic [N-1:0] SPR_l_dat,
  input  logic         SPR_l_val,
  input  logic         SPR_o_val,
  input  logic         SPR_z_val,
  output logic         RF_wr_en,
  output logic [O-1:0] RF_wr_adr,
  output logic [N-1:0] RF_wr_dat,
  output logic [N-1:0] SPR_h,
  output logic [N-1:0] SPR_l,
  output logic         SPR_o,
  output logic         SPR_z,
  output logic         busy
);

  wb_state_e    r_state;
  logic [2:0]   r_pending;
  logic [O-1:0] r_adr [3];
  logic [N-1:0] r_dat [3];

  logic         w_accept;
  logic [2:0]   w_new_mask;
  logic [2:0]   w_next_pending;
  logic [1:0]   w_idx;
  logic [2:0]   w_clr;
  logic [O-1:0] w_sel_adr;
  logic [N-1:0] w_sel_dat;

  // Ready while at most the final beat is outstanding so a new bundle can
  // be loaded on that beat without a bubble on the RF port.
  assign in_ready = $onehot0(r_pending);
  assign busy     = |r_pending;
  assign w_accept = in_valid & in_ready;

  // Writes targeting $zero are dropped at accept time.
  assign w_new_mask = {GPR_c_val & (GPR_c_adr != O'(GPR_ZERO)),
                       GPR_b_val & (GPR_b_adr != O'(GPR_ZERO)),
                       GPR_a_val & (GPR_a_adr != O'(GPR_ZERO))};

  assign w_next_pending = w_accept ? w_new_mask : (r_pending & ~w_clr);

  alu_wb_pick u_pick (
    .mask (r_pending),
    .idx  (w_idx),
    .clr  (w_clr)
  );

  always_comb begin
    w_sel_adr = r_adr[0];
    w_sel_dat = r_dat[0];
    case (w_idx)
      2'd1: begin
        w_sel_adr = r_adr[1];
        w_sel_dat = r_dat[1];
      end
      2'd2: begin
        w_sel_adr = r_adr[2];
        w_sel_dat = r_dat[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_pending <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_adr[i] <= '0;
        r_dat[i] <= '0;
      end
      RF_wr_en  <= 1'b0;
      RF_wr_adr <= '0;
      RF_wr_dat <= '0;
      SPR_h     <= '0;
      SPR_l     <= '0;
      SPR_o     <= 1'b0;
      SPR_z     <= 1'b0;
    end else begin
      r_pending <= w_next_pending;
      r_state   <= (w_next_pending != 3'b000) ? DRAIN : IDLE;

      case (r_state)
        DRAIN: begin
          RF_wr_en  <= 1'b1;
          RF_wr_adr <= w_sel_adr;
          RF_wr_dat <= w_sel_dat;
        end
        default: RF_wr_en <= 1'b0;
      endcase

      if (w_accept) begin
        r_adr[0] <= GPR_a_adr;
        r_adr[1] <= GPR_b_adr;
        r_adr[2] <= GPR_c_adr;
        r_dat[0] <= GPR_a_dat;
        r_dat[1] <= GPR_b_dat;
        r_dat[2] <= GPR_c_dat;
        if (SPR_h_val) SPR_h <= SPR_h_dat;
        if (SPR_l_val) SPR_l <= SPR_l_dat;
        SPR_o <= SPR_o_val;
        SPR_z <= SPR_z_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_writeback_sequencer
// Self-checking bench: directed scenarios plus randomized bundles vs a queue model.
// Rev    : 1.0
// ============================================================================
module tb_alu_writeback_sequencer;

  localparam int N = 32;
  localparam int O = 5;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [O-1:0] g_adr [3];
  logic [N-1:0] g_dat [3];
  logic         g_val [3];
  logic [N-1:0] h_dat, l_dat;
  logic         h_val, l_val, o_val, z_val;
  logic         RF_wr_en;
  logic [O-1:0] RF_wr_adr;
  logic [N-1:0] RF_wr_dat;
  logic [N-1:0] SPR_h, SPR_l;
  logic         SPR_o, SPR_z, busy;

  always #5 clk = ~clk;

  alu_writeback_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .GPR_a_adr (g_adr[0]),
    .GPR_a_dat (g_dat[0]),
    .GPR_a_val (g_val[0]),
    .GPR_b_adr (g_adr[1]),
    .GPR_b_dat (g_dat[1]),
    .GPR_b_val (g_val[1]),
    .GPR_c_adr (g_adr[2]),
    .GPR_c_dat (g_dat[2]),
    .GPR_c_val (g_val[2]),
    .SPR_h_dat (h_dat),
    .SPR_h_val (h_val),
    .SPR_l_dat (l_dat),
    .SPR_l_val (l_val),
    .SPR_o_val (o_val),
    .SPR_z_val (z_val),
    .RF_wr_en  (RF_wr_en),
    .RF_wr_adr (RF_wr_adr),
    .RF_wr_dat (RF_wr_dat),
    .SPR_h     (SPR_h),
    .SPR_l     (SPR_l),
    .SPR_o     (SPR_o),
    .SPR_z     (SPR_z),
    .busy      (busy)
  );

  // Reference model: a FIFO of writes still owed to the RF port.
  typedef struct {
    logic [O-1:0] adr;
    logic [N-1:0] dat;
  } wr_t;

  wr_t          exp_q[$];
  logic         exp_en;
  logic [O-1:0] exp_adr;
  logic [N-1:0] exp_dat, exp_h, exp_l;
  logic         exp_o, exp_z;
  logic [N-1:0] dut_rf [32];
  bit           accepted;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [105:0] obs_vec();
    return {RF_wr_en, RF_wr_adr, RF_wr_dat, in_ready, busy, SPR_o, SPR_z, SPR_h, SPR_l};
  endfunction

  function automatic logic [105:0] exp_vec();
    return {exp_en, exp_adr, exp_dat, (exp_q.size() <= 1), (exp_q.size() != 0),
            exp_o, exp_z, exp_h, exp_l};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_en  = 1'b0;
    exp_adr = '0;
    exp_dat = '0;
    exp_h   = '0;
    exp_l   = '0;
    exp_o   = 1'b0;
    exp_z   = 1'b0;
    accepted = 1'b0;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g_adr[i] = '0;
      g_dat[i] = '0;
      g_val[i] = 1'b0;
    end
    h_dat = '0; l_dat = '0;
    h_val = 1'b0; l_val = 1'b0; o_val = 1'b0; z_val = 1'b0;
  endtask

  task automatic set_bundle(input logic [2:0] v,
                            input logic [O-1:0] a0, input logic [N-1:0] d0,
                            input logic [O-1:0] a1, input logic [N-1:0] d1,
                            input logic [O-1:0] a2, input logic [N-1:0] d2);
    g_val[0] = v[0]; g_adr[0] = a0; g_dat[0] = d0;
    g_val[1] = v[1]; g_adr[1] = a1; g_dat[1] = d1;
    g_val[2] = v[2]; g_adr[2] = a2; g_dat[2] = d2;
  endtask

  // One clock: model issues the oldest owed write, then takes a bundle if
  // no more than one write was outstanding before the edge.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    accepted = in_valid && (exp_q.size() <= 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      exp_en  = 1'b1;
      exp_adr = w.adr;
      exp_dat = w.dat;
    end else begin
      exp_en = 1'b0;
    end
    if (accepted) begin
      for (int i = 0; i < 3; i++) begin
        if (g_val[i] && g_adr[i] != 0) begin
          w.adr = g_adr[i];
          w.dat = g_dat[i];
          exp_q.push_back(w);
        end
      end
      if (h_val) exp_h = h_dat;
      if (l_val) exp_l = l_dat;
      exp_o = o_val;
      exp_z = z_val;
    end
    @(negedge clk);
    if (RF_wr_en) dut_rf[RF_wr_adr] = RF_wr_dat;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_init got %h exp %h", obs_vec(), exp_vec());
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    int beats = 0;
    set_bundle(3'b001, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RF_wr_en) beats++;
      if (c == 0) begin
        checks++;
        if (!(RF_wr_en === 1'b1 && RF_wr_adr === 5'd5 && RF_wr_dat === 32'hDEADBEEF)) begin
          errors++;
          $display("FAIL single_first got en=%b adr=%0d dat=%h exp en=1 adr=5 dat=deadbeef",
                   RF_wr_en, RF_wr_adr, RF_wr_dat);
        end
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (beats != 1) begin
      errors++;
      $display("FAIL single_beats got %0d exp 1", beats);
    end
  endtask

  task automatic test_triple();
    logic [O-1:0] got[$];
    set_bundle(3'b111, 5'd3, 32'h1, 5'd7, 32'h2, 5'd9, 32'h3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL triple_ready got %b exp 0", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (RF_wr_en) got.push_back(RF_wr_adr);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL triple cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (got.size() != 3 || got[0] !== 5'd3 || got[1] !== 5'd7 || got[2] !== 5'd9) begin
      errors++;
      $display("FAIL triple_order got %p exp 3,7,9", got);
    end
  endtask

  task automatic test_zero_filter();
    int beats = 0;
    set_bundle(3'b011, 5'd0, 32'h99, 5'd4, 32'h55, 5'd0, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RF_wr_en) beats++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (beats != 1 || RF_wr_adr !== 5'd4 || RF_wr_dat !== 32'h55) begin
      errors++;
      $display("FAIL zero_beats got beats=%0d adr=%0d dat=%h exp 1/4/55", beats, RF_wr_adr, RF_wr_dat);
    end
  endtask

  task automatic test_mult();
    set_bundle(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    h_dat = 32'h12345678; l_dat = 32'h9ABCDEF0;
    h_val = 1'b1; l_val = 1'b1; o_val = 1'b1; z_val = 1'b0;
    in_valid = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (!(SPR_h === 32'h12345678 && SPR_l === 32'h9ABCDEF0 && busy === 1'b0 && RF_wr_en === 1'b0)) begin
      errors++;
      $display("FAIL mult got h=%h l=%h busy=%b en=%b exp 12345678/9abcdef0/0/0",
               SPR_h, SPR_l, busy, RF_wr_en);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mult cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int phase = 0;
    int run = 0;
    int max_run = 0;
    set_bundle(3'b011, 5'd1, 32'h11, 5'd2, 32'h22, 5'd0, 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (accepted && phase == 0) begin
        set_bundle(3'b101, 5'd3, 32'h33, 5'd0, 32'd0, 5'd6, 32'h66);
        z_val = 1'b1;
        phase = 1;
      end else if (accepted && phase == 1) begin
        clear_inputs();
        phase = 2;
      end
      run = RF_wr_en ? run + 1 : 0;
      if (run > max_run) max_run = run;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (max_run != 4) begin
      errors++;
      $display("FAIL b2b_contiguous got run %0d exp 4", max_run);
    end
  endtask

  task automatic test_duplicate();
    set_bundle(3'b111, 5'd7, 32'hA, 5'd7, 32'hB, 5'd7, 32'hC);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL dup cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (dut_rf[7] !== 32'hC) begin
      errors++;
      $display("FAIL dup_last_wins got %h exp c", dut_rf[7]);
    end
  endtask

  task automatic test_random();
    clear_inputs();
    accepted = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || accepted) begin
        for (int i = 0; i < 3; i++) begin
          g_val[i] = 1'($urandom_range(0, 1));
          g_adr[i] = 5'($urandom_range(0, 7));
          g_dat[i] = $urandom;
        end
        h_dat = $urandom; l_dat = $urandom;
        h_val = 1'($urandom_range(0, 1));
        l_val = 1'($urandom_range(0, 1));
        o_val = 1'($urandom_range(0, 1));
        z_val = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    set_bundle(3'b111, 5'd10, 32'hAA, 5'd11, 32'hBB, 5'd12, 32'hCC);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid got %h exp %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_after cyc%0d got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    test_reset();
    test_single();
    test_triple();
    test_zero_filter();
    test_mult();
    test_back_to_back();
    test_duplicate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
